risc8_uart_rx: RTL and testbench
================================

// Module: risc8_uart_rx
// PURPOSE
//  Receive half of the risc8 UART: IO-bus peripheral that deserialises 8N1
//  async serial from rx_in and buffers received bytes in a small FIFO for the
//  CPU. Shares the IO bus protocol of the other risc8 peripherals: registered
//  read data, one-cycle valid pulse, and address decode against BASE.
// PARAMETERS
//  BASE        7'h30  IO address of register 0; the block decodes BASE+0..BASE+2
//  FIFO_DEPTH  4      receive FIFO entries; power of two, 2..16
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  reset     in   1  asynchronous, active-low reset
//  ren       in   1  IO read strobe
//  wen       in   1  IO write strobe
//  addr      in   7  IO address
//  wdata     in   8  IO write data
//  rdata     out  8  IO read data, registered
//  valid     out  1  one-cycle pulse; rdata is valid when set
//  rx_in     in   1  serial input, asynchronous to clk, idle high
//  rx_irq    out  1  level, high while the FIFO is non-empty
// BEHAVIOUR
//  Registers:
//   BASE+0  R/W  baud_div; reset value 8'h05. One bit period = baud_div+1 clks.
//   BASE+1  R    status = {4'b0, frame_err, overrun, full, avail}.
//           W    write 1 to bit3 or bit2 clears that flag; bits 1:0 ignore writes.
//   BASE+2  R    pops the FIFO head. If the FIFO is empty, returns 8'h00 with no state change.
//  Bus:
//   - Read of a decoded address: rdata and valid=1 in the next cycle.
//   - Other addresses: valid=0 and rdata holds its value.
//   - valid defaults to 0 every cycle.
//  Reset (reset=0): rdata=0, valid=0, baud_div=5, FIFO empty, flags=0,
//   rx_irq=0, FSM=IDLE. Applies immediately, including mid-frame; any partial byte is discarded.
//  Input sync: rx_in passes through a 2-flop synchroniser; the sync flops reset to 1.
//   All FSM decisions use the synchronised signal rxs.
//  FSM (counter cnt[7:0] counts down to 0, then the action fires):
//   IDLE : rxs==0 -> cnt=baud_div>>1, go to START.
//   START: at cnt==0, sample rxs. If 0: cnt=baud_div, bit index=0, go to DATA.
//          If 1: glitch, go to IDLE.
//   DATA : at cnt==0, shift rxs into shreg, LSB first, and reload cnt=baud_div.
//          After the 8th bit, go to STOP.
//   STOP : at cnt==0, sample rxs.
//          If 1: push shreg; if the FIFO is full, drop the byte and set overrun.
//          If 0: set frame_err and drop the byte. Then go to IDLE.
//          A new start bit is detected from the cycle after STOP.
//  baud_div writes mid-frame take effect at the next cnt reload.
//  FIFO:
//   - avail = count!=0; full = count==FIFO_DEPTH.
//   - Push and pop in the same cycle: both happen. Push while full: the push is
//     dropped even if a pop occurs in the same cycle. Pop on empty: no-op.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Status read in the same cycle as a push or pop returns pre-update values.
//  Simultaneous W1C and hardware set of the same flag: the set wins.
// TESTING
//  1 baud_div=5 (6 clk/bit); send 0xA5 8N1 -> status read 0x01, rx_irq=1;
//    BASE+2 read 0xA5; then status 0x00, rx_irq=0.
//  2 rx_in low for 2 clks, then high -> FSM returns to IDLE, status 0x00, no byte pushed.
//  3 send 0x3C with stop bit low -> status 0x08, FIFO empty;
//    write 0x08 to BASE+1 -> status 0x00.
//  4 send 0x11,0x22,0x33,0x44,0x55 without reading -> status 0x07;
//    reads return 0x11..0x44, then 0x00 with status 0x04.
//  5 pop BASE+2 in the same cycle as a stop-bit push with count=1 -> count stays 1;
//    the next read returns the new byte.
//  6 assert reset in the middle of DATA, then release and send 0x5A ->
//    only 0x5A is received; baud_div reads 0x05.

Source files
------------

// File: rtl/risc8_uart_rx.sv
// ============================================================================
// Module      : risc8_uart_rx
// Description : risc8 UART receiver. IO-bus peripheral that deserialises 8N1
//               serial data into a small receive FIFO for the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc8_uart_rx #(
  parameter logic [6:0] BASE       = 7'h30,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ren,
  input  logic       wen,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       valid,
  input  logic       rx_in,
  output logic       rx_irq
);

  localparam int              c_PW         = $clog2(FIFO_DEPTH);
  localparam int              c_CW         = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL_CNT   = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE    = c_PW'(1);
  localparam logic [6:0]      c_ADDR_BAUD  = BASE;
  localparam logic [6:0]      c_ADDR_STAT  = BASE + 7'd1;
  localparam logic [6:0]      c_ADDR_DATA  = BASE + 7'd2;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  logic            r_rx_meta;
  logic            r_rxs;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shreg;
  logic [7:0]      w_shreg_nxt;
  logic            w_cnt_zero;
  logic            w_stop_sample;
  logic            w_rx_push;
  logic            w_frame_set;

  logic [7:0]      r_baud_div;
  logic            r_frame_err;
  logic            r_overrun;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            w_avail;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_overrun_set;
  logic            w_wr_stat;
  logic            w_addr_hit;
  logic [7:0]      w_rd_mux;

  // rx_in is asynchronous; everything downstream uses r_rxs only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx_in;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 8'd0;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'd0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shreg   <= w_shreg_nxt;
    end
  end

  assign w_cnt_zero = (r_cnt == 8'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shreg_nxt = r_shreg;
    case (r_state)
      c_ST_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt = c_ST_START;
          w_cnt_nxt   = r_baud_div >> 1;
        end
      end
      c_ST_START: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (!r_rxs) begin
          w_state_nxt = c_ST_DATA;
          w_cnt_nxt   = r_baud_div;
          w_bit_nxt   = 3'd0;
        end else begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      c_ST_DATA: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_shreg_nxt = {r_rxs, r_shreg[7:1]};
          w_cnt_nxt   = r_baud_div;
          if (r_bit_idx == 3'd7) w_state_nxt = c_ST_STOP;
          else                   w_bit_nxt   = r_bit_idx + 3'd1;
        end
      end
      c_ST_STOP: begin
        if (!w_cnt_zero) w_cnt_nxt   = r_cnt - 8'd1;
        else             w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_stop_sample = (r_state == c_ST_STOP) && w_cnt_zero;
    w_rx_push     = w_stop_sample && r_rxs;
    w_frame_set   = w_stop_sample && !r_rxs;
  end

  assign w_avail       = (r_count != '0);
  assign w_full        = (r_count == c_FULL_CNT);
  assign w_push        = w_rx_push && !w_full;
  assign w_overrun_set = w_rx_push && w_full;
  assign w_pop         = ren && (addr == c_ADDR_DATA) && w_avail;
  assign w_wr_stat     = wen && (addr == c_ADDR_STAT);
  assign rx_irq        = w_avail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud_div  <= 8'h05;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (wen && (addr == c_ADDR_BAUD)) r_baud_div <= wdata;
      // hardware set takes priority over a simultaneous software clear
      if (w_frame_set)                 r_frame_err <= 1'b1;
      else if (w_wr_stat && wdata[3])  r_frame_err <= 1'b0;
      if (w_overrun_set)               r_overrun   <= 1'b1;
      else if (w_wr_stat && wdata[2])  r_overrun   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shreg;
  end

  always_comb begin
    w_rd_mux   = 8'h00;
    w_addr_hit = 1'b1;
    case (addr)
      c_ADDR_BAUD: w_rd_mux = r_baud_div;
      c_ADDR_STAT: w_rd_mux = {4'b0, r_frame_err, r_overrun, w_full, w_avail};
      c_ADDR_DATA: w_rd_mux = w_avail ? r_mem[r_rd_ptr] : 8'h00;
      default:     w_addr_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= 8'h00;
      valid <= 1'b0;
    end else begin
      valid <= ren && w_addr_hit;
      if (ren && w_addr_hit) rdata <= w_rd_mux;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_risc8_uart_rx.sv
// ============================================================================
// Module      : tb_risc8_uart_rx
// Description : Directed self-checking bench for risc8_uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_risc8_uart_rx;

  localparam logic [6:0] A_BAUD = 7'h30;
  localparam logic [6:0] A_STAT = 7'h31;
  localparam logic [6:0] A_DATA = 7'h32;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       ren   = 1'b0;
  logic       wen   = 1'b0;
  logic [6:0] addr  = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic       rx_in = 1'b1;
  logic [7:0] rdata;
  logic       valid;
  logic       rx_irq;

  int total = 0;
  int bad   = 0;

  risc8_uart_rx #(.BASE(7'h30), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .ren    (ren),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .valid  (valid),
    .rx_in  (rx_in),
    .rx_irq (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic bus_read(input logic [6:0] a, output logic [7:0] d, output logic v);
    @(negedge clk);
    ren  = 1'b1;
    addr = a;
    @(posedge clk);
    #1;
    ren = 1'b0;
    d   = rdata;
    v   = valid;
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    wen   = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int bclk);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      rx_in = fr[b];
      repeat (bclk) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic       v;
    repeat (3) @(negedge clk);
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", rx_irq); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h00 || v !== 1'b1) begin bad++; $display("FAIL reset_status: got %h/%b want 00/1", d, v); end
    bus_read(A_BAUD, d, v);
    total++; if (d !== 8'h05 || v !== 1'b1) begin bad++; $display("FAIL reset_baud: got %h/%b want 05/1", d, v); end
    bus_read(7'h33, d, v);
    total++; if (d !== 8'h05 || v !== 1'b0) begin bad++; $display("FAIL unmapped_read: got %h/%b want 05/0", d, v); end
  endtask

  task automatic test_single_byte;
    logic [7:0] d;
    logic       v;
    send_byte(8'hA5, 1'b1, 6);
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL single_status: got %h want 01", d); end
    total++; if (rx_irq !== 1'b1) begin bad++; $display("FAIL single_irq: got %b want 1", rx_irq); end
    bus_read(A_DATA, d, v);
    total++; if (d !== 8'hA5 || v !== 1'b1) begin bad++; $display("FAIL single_data: got %h/%b want a5/1", d, v); end
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL single_status_after: got %h want 00", d); end
    @(negedge clk);
    total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL single_irq_after: got %b want 0", rx_irq); end
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    logic       v;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (12) @(negedge clk);
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL glitch_status: got %h want 00", d); end
    total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL glitch_irq: got %b want 0", rx_irq); end
    send_byte(8'h81, 1'b1, 6);
    bus_read(A_DATA, d, v);
    total++; if (d !== 8'h81) begin bad++; $display("FAIL glitch_next_byte: got %h want 81", d); end
  endtask

  task automatic test_frame_err;
    logic [7:0] d;
    logic       v;
    send_byte(8'h3C, 1'b0, 6);
    repeat (10) @(negedge clk);
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h08) begin bad++; $display("FAIL frame_status: got %h want 08", d); end
    total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL frame_irq: got %b want 0", rx_irq); end
    bus_write(A_STAT, 8'h08);
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL frame_clear: got %h want 00", d); end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    logic       v;
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_byte(8'h11, 1'b1, 6);
    send_byte(8'h22, 1'b1, 6);
    send_byte(8'h33, 1'b1, 6);
    send_byte(8'h44, 1'b1, 6);
    send_byte(8'h55, 1'b1, 6);
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h07) begin bad++; $display("FAIL overrun_status: got %h want 07", d); end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d, v);
      total++; if (d !== exp_b[i]) begin bad++; $display("FAIL overrun_pop%0d: got %h want %h", i, d, exp_b[i]); end
    end
    bus_read(A_DATA, d, v);
    total++; if (d !== 8'h00 || v !== 1'b1) begin bad++; $display("FAIL empty_pop: got %h/%b want 00/1", d, v); end
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL overrun_sticky: got %h want 04", d); end
    bus_write(A_STAT, 8'h07);
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL overrun_clear: got %h want 00", d); end
  endtask

  task automatic test_baud_change;
    logic [7:0] d;
    logic       v;
    bus_write(A_BAUD, 8'h03);
    bus_read(A_BAUD, d, v);
    total++; if (d !== 8'h03) begin bad++; $display("FAIL baud_readback: got %h want 03", d); end
    send_byte(8'hC3, 1'b1, 4);
    bus_read(A_DATA, d, v);
    total++; if (d !== 8'hC3) begin bad++; $display("FAIL baud4_data: got %h want c3", d); end
    bus_write(A_BAUD, 8'h05);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    logic       v;
    logic [9:0] fr;
    send_byte(8'h66, 1'b1, 6);
    fr = {1'b1, 8'h99, 1'b0};
    // stop-bit push lands on the 60th posedge; the pop is presented for that same edge
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      if (i == 60) begin
        total++; if (rdata !== 8'h66 || valid !== 1'b1) begin bad++; $display("FAIL b2b_pop: got %h/%b want 66/1", rdata, valid); end
      end
      rx_in = (i < 60) ? fr[i / 6] : 1'b1;
      ren   = (i == 59);
      addr  = A_DATA;
    end
    ren = 1'b0;
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL b2b_status: got %h want 01", d); end
    bus_read(A_DATA, d, v);
    total++; if (d !== 8'h99) begin bad++; $display("FAIL b2b_new_byte: got %h want 99", d); end
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL b2b_empty: got %h want 00", d); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    logic       v;
    logic [9:0] fr;
    send_byte(8'h77, 1'b1, 6);
    bus_write(A_BAUD, 8'h07);
    fr = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rx_in = fr[i / 8];
    end
    reset = 1'b0;
    #1;
    total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b want 0", rx_irq); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL midreset_rdata: got %h want 00", rdata); end
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(A_BAUD, d, v);
    total++; if (d !== 8'h05) begin bad++; $display("FAIL midreset_baud: got %h want 05", d); end
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL midreset_status: got %h want 00", d); end
    send_byte(8'h5A, 1'b1, 6);
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL after_reset_status: got %h want 01", d); end
    bus_read(A_DATA, d, v);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL after_reset_data: got %h want 5a", d); end
    bus_read(A_STAT, d, v);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL after_reset_empty: got %h want 00", d); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_baud_change;
    test_back_to_back;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
